// File: rtl/y_drop_ctrl_pkg.sv
// Shared geometry constants and FSM encoding for the block-stack drop controller.
// The geometry values match the y register's reset value (Y_INIT).
package y_drop_ctrl_pkg;

  localparam int unsigned Y_W    = 7;   // y position width
  localparam int unsigned LVL_W  = 3;   // tower level width
  localparam int unsigned CALC_W = 8;   // widened arithmetic, avoids 7-bit wrap

  localparam logic [Y_W-1:0]   Y_INIT        = 7'd104;  // landing y of level 0
  localparam logic [Y_W-1:0]   Y_TOP         = 7'd0;    // spawn y of a dropping block
  localparam logic [Y_W-1:0]   BLOCK_H       = 7'd16;   // one level in pixels
  localparam logic [Y_W-1:0]   DROP_STEP_DEF = 7'd2;    // default pixels per frame
  localparam logic [LVL_W-1:0] MAX_LEVEL     = 3'd7;    // tower capacity in levels

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DROP = 2'd1,
    S_LAND = 2'd2,
    S_FULL = 2'd3
  } state_e;

  // Landing y for a tower that already holds lvl blocks.
  function automatic logic [CALC_W-1:0] land_y_f(input logic [LVL_W-1:0] lvl);
    return CALC_W'(Y_INIT) - CALC_W'(lvl) * CALC_W'(BLOCK_H);
  endfunction

endpackage

// File: rtl/y_drop_ctrl.sv
// Drop controller for the block-stack y position register.
// On place, spawns a block at Y_TOP and steps it down by DROP_STEP per frame_tick,
// clamping at the current landing height, then counts the landed level.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   frame_tick      - one-cycle pulse per animation frame
//   place           - one-cycle request to spawn and drop a block
//   y_value         - y value for the y register's parallel load
//   y_parload       - one-cycle load strobe for y_value
//   y_enable        - hold enable to the y register, high during a drop
//   level           - blocks landed so far
//   busy            - high while dropping or landing
//   landed          - one-cycle pulse when a block settles
//   tower_full      - high once the tower holds MAX_LEVEL blocks
module y_drop_ctrl
  import y_drop_ctrl_pkg::*;
#(
  parameter logic [Y_W-1:0] DROP_STEP = DROP_STEP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             place,
  output logic [Y_W-1:0]   y_value,
  output logic             y_parload,
  output logic             y_enable,
  output logic [LVL_W-1:0] level,
  output logic             busy,
  output logic             landed,
  output logic             tower_full
);

  // Geometry legality: the top level must still land at or below the spawn row.
  if (int'(Y_INIT) - (int'(MAX_LEVEL) - 1) * int'(BLOCK_H) < int'(Y_TOP)) begin : g_geom_chk
    $error("y_drop_ctrl: tower of MAX_LEVEL blocks does not fit below Y_TOP");
  end
  if (DROP_STEP == '0) begin : g_step_chk
    $error("y_drop_ctrl: DROP_STEP must be non-zero");
  end

  state_e              state_q;
  logic [Y_W-1:0]      y_value_q;
  logic                parload_q;
  logic                enable_q;
  logic                busy_q;
  logic                landed_q;
  logic                full_q;
  logic [LVL_W-1:0]    level_q;
  logic [CALC_W-1:0]   land_y_q;

  logic [CALC_W-1:0]   y_nxt_d;
  logic [LVL_W-1:0]    level_d;

  // Next drop position in 8 bits so the overshoot compare never wraps.
  assign y_nxt_d = CALC_W'(y_value_q) + CALC_W'(DROP_STEP);
  assign level_d = level_q + LVL_W'(1);

  // Controller FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      y_value_q <= Y_INIT;
      parload_q <= 1'b0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      landed_q  <= 1'b0;
      full_q    <= 1'b0;
      level_q   <= '0;
      land_y_q  <= land_y_f('0);
    end else begin
      parload_q <= 1'b0;
      landed_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // A coincident frame_tick is deliberately ignored here.
          if (place && !full_q) begin
            y_value_q <= Y_TOP;
            parload_q <= 1'b1;
            enable_q  <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_DROP;
          end
        end
        S_DROP: begin
          if (frame_tick) begin
            parload_q <= 1'b1;
            if (y_nxt_d >= land_y_q) begin
              // Clamp so a non-dividing step never overshoots the tower top.
              y_value_q <= Y_W'(land_y_q);
              enable_q  <= 1'b0;
              state_q   <= S_LAND;
            end else begin
              y_value_q <= Y_W'(y_nxt_d);
            end
          end
        end
        S_LAND: begin
          landed_q <= 1'b1;
          busy_q   <= 1'b0;
          level_q  <= level_d;
          land_y_q <= land_y_f(level_d);
          if (level_d == MAX_LEVEL) begin
            full_q  <= 1'b1;
            state_q <= S_FULL;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_FULL: begin
          // Terminal until reset.
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign y_value    = y_value_q;
  assign y_parload  = parload_q;
  assign y_enable   = enable_q;
  assign busy       = busy_q;
  assign landed     = landed_q;
  assign tower_full = full_q;
  assign level      = level_q;

endmodule

// File: tb/tb_y_drop_ctrl.sv
// Scoreboard bench for y_drop_ctrl: two instances (step 2 and step 6) with
// independent stimulus; expected y loads are queued as stimulus is driven and
// checked whenever the DUT strobes y_parload.
module tb_y_drop_ctrl;
  import y_drop_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset      [2];
  logic             place      [2];
  logic             tick       [2];
  logic [Y_W-1:0]   y_value    [2];
  logic             y_parload  [2];
  logic             y_enable   [2];
  logic [LVL_W-1:0] level      [2];
  logic             busy       [2];
  logic             landed     [2];
  logic             tower_full [2];

  y_drop_ctrl #(.DROP_STEP(7'd2)) u_dut_s2 (
    .clk(clk), .reset(reset[0]), .frame_tick(tick[0]), .place(place[0]),
    .y_value(y_value[0]), .y_parload(y_parload[0]), .y_enable(y_enable[0]),
    .level(level[0]), .busy(busy[0]), .landed(landed[0]), .tower_full(tower_full[0])
  );

  y_drop_ctrl #(.DROP_STEP(7'd6)) u_dut_s6 (
    .clk(clk), .reset(reset[1]), .frame_tick(tick[1]), .place(place[1]),
    .y_value(y_value[1]), .y_parload(y_parload[1]), .y_enable(y_enable[1]),
    .level(level[1]), .busy(busy[1]), .landed(landed[1]), .tower_full(tower_full[1])
  );

  int n_cmp = 0;
  int n_mis = 0;
  int exp_q0[$];
  int exp_q1[$];
  int landed_cnt  [2] = '{0, 0};
  int parload_cnt [2] = '{0, 0};
  int y_m         [2] = '{0, 0};
  int lvl_m       [2] = '{0, 0};
  int step_m      [2] = '{2, 6};

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic sb_push(input int idx, input int v);
    if (idx == 0) exp_q0.push_back(v);
    else          exp_q1.push_back(v);
  endtask

  task automatic sb_pop_check(input int idx);
    int e;
    if ((idx == 0 && exp_q0.size() == 0) || (idx == 1 && exp_q1.size() == 0)) begin
      chk($sformatf("spurious_parload[%0d] y=%0d", idx, y_value[idx]), int'(y_parload[idx]), 0);
    end else begin
      if (idx == 0) e = exp_q0.pop_front();
      else          e = exp_q1.pop_front();
      chk($sformatf("y_load[%0d]", idx), int'(y_value[idx]), e);
    end
  endtask

  // Output monitor: pops the scoreboard on every load strobe.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (landed[i] === 1'b1) landed_cnt[i]++;
      if (y_parload[i] === 1'b1) begin
        parload_cnt[i]++;
        sb_pop_check(i);
      end
    end
  end

  // One placement; ticks every 4 cycles. Stops early when y reaches stop_at.
  task automatic drop(input int idx, input bit reject, input int stop_at, output int ticks);
    int  land;
    int  lc0;
    bit  done;
    bit  stopped;
    land    = int'(Y_INIT) - lvl_m[idx] * int'(BLOCK_H);
    lc0     = landed_cnt[idx];
    ticks   = 0;
    done    = 1'b0;
    stopped = 1'b0;
    @(negedge clk);
    place[idx] = 1'b1;
    y_m[idx]   = int'(Y_TOP);
    sb_push(idx, y_m[idx]);
    @(negedge clk);
    place[idx] = 1'b0;
    while (!done && !stopped && ticks < 100) begin
      @(negedge clk);
      tick[idx] = 1'b1;
      ticks++;
      if (y_m[idx] + step_m[idx] >= land) begin
        y_m[idx] = land;
        done     = 1'b1;
      end else begin
        y_m[idx] = y_m[idx] + step_m[idx];
      end
      sb_push(idx, y_m[idx]);
      @(negedge clk);
      tick[idx] = 1'b0;
      if (reject && ticks == 5) place[idx] = 1'b1;
      @(negedge clk);
      place[idx] = 1'b0;
      @(negedge clk);
      #1;
      if (!done && ticks == 1) begin
        chk($sformatf("busy_in_drop[%0d]", idx), int'(busy[idx]), 1);
        chk($sformatf("enable_in_drop[%0d]", idx), int'(y_enable[idx]), 1);
      end
      if (!done && y_m[idx] == stop_at) stopped = 1'b1;
    end
    if (done) begin
      lvl_m[idx]++;
      chk($sformatf("landed_once[%0d]", idx), landed_cnt[idx], lc0 + 1);
      chk($sformatf("level[%0d]", idx), int'(level[idx]), lvl_m[idx]);
      chk($sformatf("land_y[%0d]", idx), int'(y_value[idx]), land);
      chk($sformatf("busy_after_land[%0d]", idx), int'(busy[idx]), 0);
      chk($sformatf("enable_after_land[%0d]", idx), int'(y_enable[idx]), 0);
    end else if (!stopped) begin
      chk($sformatf("drop_timeout[%0d]", idx), ticks, -1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int lc;
    int pc;
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1;
      place[i] = 1'b0;
      tick[i]  = 1'b0;
    end
    repeat (2) @(negedge clk);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_y[%0d]", i), int'(y_value[i]), 104);
      chk($sformatf("rst_level[%0d]", i), int'(level[i]), 0);
      chk($sformatf("rst_parload[%0d]", i), int'(y_parload[i]), 0);
      chk($sformatf("rst_enable[%0d]", i), int'(y_enable[i]), 0);
      chk($sformatf("rst_busy[%0d]", i), int'(busy[i]), 0);
      chk($sformatf("rst_landed[%0d]", i), int'(landed[i]), 0);
      chk($sformatf("rst_full[%0d]", i), int'(tower_full[i]), 0);
    end

    // frame_tick in IDLE must not load anything
    pc = parload_cnt[0];
    @(negedge clk); tick[0] = 1'b1;
    @(negedge clk); tick[0] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_tick_ignored", parload_cnt[0] - pc, 0);

    // first drop, with a rejected place mid-drop
    drop(0, 1'b1, -1, t);
    chk("drop1_ticks", t, 52);
    drop(0, 1'b0, -1, t);
    chk("drop2_ticks", t, 44);

    // third drop aborted by reset at y=30
    drop(0, 1'b0, 30, t);
    chk("abort_y", int'(y_value[0]), 30);
    lc = landed_cnt[0];
    @(negedge clk); reset[0] = 1'b1;
    @(negedge clk); reset[0] = 1'b0;
    #1;
    lvl_m[0] = 0;
    chk("abort_rst_y", int'(y_value[0]), 104);
    chk("abort_rst_level", int'(level[0]), 0);
    chk("abort_rst_busy", int'(busy[0]), 0);
    chk("abort_rst_enable", int'(y_enable[0]), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("abort_no_landed", landed_cnt[0], lc);

    // fill the tower
    for (int k = 0; k < 7; k++) begin
      drop(0, 1'b0, -1, t);
      chk($sformatf("fill_land_%0d", k), int'(y_value[0]), 104 - 16 * k);
      if (k < 6) chk($sformatf("fill_not_full_%0d", k), int'(tower_full[0]), 0);
    end
    chk("full_flag", int'(tower_full[0]), 1);
    chk("full_level", int'(level[0]), 7);
    pc = parload_cnt[0];
    @(negedge clk); place[0] = 1'b1;
    @(negedge clk); place[0] = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("full_place_ignored", parload_cnt[0] - pc, 0);
    chk("full_busy", int'(busy[0]), 0);
    chk("full_enable", int'(y_enable[0]), 0);

    // step 6: clamps at 104 then at 88
    drop(1, 1'b0, -1, t);
    chk("s6_drop1_ticks", t, 18);
    drop(1, 1'b0, -1, t);
    chk("s6_drop2_ticks", t, 15);
    chk("s6_clamp88", int'(y_value[1]), 88);

    repeat (2) @(negedge clk);
    #1;
    chk("sb0_drained", exp_q0.size(), 0);
    chk("sb1_drained", exp_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
